bs_result_collector: RTL and testbench

BS_RESULT_COLLECTOR -- requirements
Module: bs_result_collector

---
 rtl/bs_result_collector_pkg.sv | 24 ++
 rtl/bs_result_fifo.sv | 80 ++++++++
 rtl/bs_result_collector.sv | 150 +++++++++++++++
 tb/tb_bs_result_collector.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bs_result_collector_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : bs_result_collector_pkg
// Desc   : Shared Black-Scholes defaults, collector FSM encoding, index helper.
// Rev    : 1.0
//------------------------------------------------------------------------------
package bs_result_collector_pkg;

   localparam int BS_BSMODS_DEFAULT = 4;
   localparam int BS_DATA_W_DEFAULT = 32;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SERVE   = 2'd1,
      ST_BLOCKED = 2'd2
   } bs_coll_state_e;

   // Index width that never collapses to zero bits for single-entry cases.
   function automatic int bs_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bs_result_fifo.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : bs_result_fifo
// Desc   : First-word-fall-through FIFO with flush; power-of-two depth.
// Rev    : 1.0
//------------------------------------------------------------------------------
module bs_result_fifo
   import bs_result_collector_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = 34
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o
);

   localparam int             PTR_W    = bs_idx_w(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = DEPTH;
   localparam logic [PTR_W:0] CNT_ONE  = 1;
   localparam logic [PTR_W-1:0] PTR_ONE = 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic [PTR_W:0]   count_d;
   logic             do_push;
   logic             do_pop;

   assign valid_o = (count_q != '0);
   assign full_o  = (count_q == FULL_CNT);
   assign do_pop  = pop_i & valid_o & ~flush_i;
   // A push into a full FIFO is legal only when the head leaves this cycle.
   assign do_push = push_i & (~full_o | do_pop) & ~flush_i;
   assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + CNT_ONE;
      end else if (!do_push && do_pop) begin
         count_d = count_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
         count_q <= count_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/bs_result_collector.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : bs_result_collector
// Desc   : Round-robin collector of Black-Scholes results into an output FIFO.
//          Define BS_COLLECTOR_STATS_EN to build the result/stall counters.
// Rev    : 1.0
//------------------------------------------------------------------------------
module bs_result_collector
   import bs_result_collector_pkg::*;
#(
   parameter int  BSMODS     = BS_BSMODS_DEFAULT,
   parameter int  DATA_W     = BS_DATA_W_DEFAULT,
   parameter int  FIFO_DEPTH = 8,
   localparam int ID_W       = bs_idx_w(BSMODS)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [BSMODS-1:0]        BS_DONE,
   input  logic [BSMODS*DATA_W-1:0] bs_result,
   output logic [BSMODS-1:0]        result_ack,
   input  logic                     flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic [ID_W-1:0]          out_id,
   output logic                     fifo_full,
   output logic [15:0]              result_count,
   output logic [15:0]              stall_count
);

   localparam int ENT_W = ID_W + DATA_W;

   bs_coll_state_e    state_q;
   logic [ID_W-1:0]   last_grant_q;
   logic [BSMODS-1:0] ack_mask_q;
   logic [BSMODS-1:0] pending;
   logic [ID_W-1:0]   cand;
   logic [ID_W-1:0]   grant_idx;
   logic              grant_found;
   logic              grant;
   logic              pop;
   logic              fifo_valid;
   logic [ENT_W-1:0]  head;
   logic [DATA_W-1:0] res_arr [BSMODS];

   for (genvar i = 0; i < BSMODS; i++) begin : g_unpack
      assign res_arr[i] = bs_result[i*DATA_W +: DATA_W];
   end

   assign pending   = BS_DONE & ~ack_mask_q;
   assign out_valid = fifo_valid & ~flush;
   assign pop       = out_valid & out_ready;

   // Walk downward so the nearest index after last_grant wins the final write.
   always_comb begin
      cand        = '0;
      grant_idx   = '0;
      grant_found = 1'b0;
      for (int k = BSMODS; k >= 1; k--) begin
         cand = ID_W'((int'(last_grant_q) + k) % BSMODS);
         if (pending[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   assign grant = grant_found & (~fifo_full | pop) & ~flush & reset;

   always_comb begin
      result_ack = '0;
      if (grant) begin
         result_ack[grant_idx] = 1'b1;
      end
   end

   bs_result_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENT_W)
   ) u_fifo (
      .clk_i   (clock),
      .rst_ni  (reset),
      .flush_i (flush),
      .push_i  (grant),
      .data_i  ({grant_idx, res_arr[grant_idx]}),
      .pop_i   (pop),
      .valid_o (fifo_valid),
      .data_o  (head),
      .full_o  (fifo_full)
   );

   assign out_id   = head[ENT_W-1 -: ID_W];
   assign out_data = head[DATA_W-1:0];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         last_grant_q <= ID_W'(BSMODS - 1);
         ack_mask_q   <= '0;
      end else begin
         ack_mask_q <= result_ack;
         if (grant) begin
            last_grant_q <= grant_idx;
         end
         if (flush || pending == '0) begin
            state_q <= ST_IDLE;
         end else begin
            case (state_q)
               ST_IDLE:    state_q <= (fifo_full && !pop) ? ST_BLOCKED : ST_SERVE;
               ST_SERVE:   if (fifo_full && !pop) state_q <= ST_BLOCKED;
               ST_BLOCKED: if (pop) state_q <= ST_SERVE;
               default:    state_q <= ST_IDLE;
            endcase
         end
      end
   end

`ifdef BS_COLLECTOR_STATS_EN
   logic [15:0] result_count_q;
   logic [15:0] stall_count_q;
   logic        stall;

   assign stall = (pending != '0) & fifo_full & ~pop & ~flush;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         result_count_q <= '0;
         stall_count_q  <= '0;
      end else if (flush) begin
         result_count_q <= '0;
         stall_count_q  <= '0;
      end else begin
         if (grant && result_count_q != 16'hFFFF) begin
            result_count_q <= result_count_q + 16'd1;
         end
         if (stall && stall_count_q != 16'hFFFF) begin
            stall_count_q <= stall_count_q + 16'd1;
         end
      end
   end

   assign result_count = result_count_q;
   assign stall_count  = stall_count_q;
`else
   assign result_count = '0;
   assign stall_count  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bs_result_collector.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : tb_bs_result_collector
// Desc   : Directed vector table plus hand sequences for bs_result_collector.
// Rev    : 1.0
//------------------------------------------------------------------------------
module tb_bs_result_collector;

`ifdef BS_COLLECTOR_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic         clock = 1'b0;
   logic         reset;
   logic [3:0]   BS_DONE;
   logic [127:0] bs_result;
   logic [3:0]   result_ack;
   logic         flush;
   logic         out_valid;
   logic         out_ready;
   logic [31:0]  out_data;
   logic [1:0]   out_id;
   logic         fifo_full;
   logic [15:0]  result_count;
   logic [15:0]  stall_count;
   logic [3:0]   ack_seen;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [3:0]  done;
      logic [3:0]  ack;
      logic        valid;
      logic [1:0]  id;
      logic [31:0] data;
   } vec_t;

   vec_t tbl [8];

   always #5 clock = ~clock;

   bs_result_collector #(
      .BSMODS     (4),
      .DATA_W     (32),
      .FIFO_DEPTH (8)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .BS_DONE      (BS_DONE),
      .bs_result    (bs_result),
      .result_ack   (result_ack),
      .flush        (flush),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_id       (out_id),
      .fifo_full    (fifo_full),
      .result_count (result_count),
      .stall_count  (stall_count)
   );

   function automatic logic [31:0] res_of(input int i);
      case (i)
         0:       return 32'h1111_0000;
         1:       return 32'h2222_0001;
         2:       return 32'hDEAD_BEEF;
         default: return 32'h4444_0003;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Modules drop BS_DONE right after the edge that captured their ack.
   task automatic adv();
      ack_seen = result_ack;
      @(posedge clock);
      #1;
      BS_DONE = BS_DONE & ~ack_seen;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish before timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{4'b0100, 4'b0100, 1'b1, 2'd2, 32'hDEAD_BEEF};
      tbl[1] = '{4'b1111, 4'b1000, 1'b1, 2'd3, 32'h4444_0003};
      tbl[2] = '{4'b0011, 4'b0001, 1'b1, 2'd0, 32'h1111_0000};
      tbl[3] = '{4'b1001, 4'b1000, 1'b1, 2'd3, 32'h4444_0003};
      tbl[4] = '{4'b0110, 4'b0010, 1'b1, 2'd1, 32'h2222_0001};
      tbl[5] = '{4'b0011, 4'b0001, 1'b1, 2'd0, 32'h1111_0000};
      tbl[6] = '{4'b0001, 4'b0001, 1'b1, 2'd0, 32'h1111_0000};
      tbl[7] = '{4'b0000, 4'b0000, 1'b0, 2'd0, 32'h0000_0000};

      bs_result = {32'h4444_0003, 32'hDEAD_BEEF, 32'h2222_0001, 32'h1111_0000};
      reset     = 1'b0;
      BS_DONE   = 4'b1111;
      flush     = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_ack", 32'(result_ack), 32'h0);
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_data", out_data, 32'h0);
      chk("rst_id", 32'(out_id), 32'h0);
      chk("rst_full", 32'(fifo_full), 32'h0);
      chk("rst_rcnt", 32'(result_count), 32'h0);
      chk("rst_scnt", 32'(stall_count), 32'h0);
      reset = 1'b1;

      // All modules done at once: 0,1,2,3 in consecutive cycles.
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         chk("all_ack", 32'(result_ack), 32'(1) << k);
         if (k > 0) begin
            chk("all_valid", 32'(out_valid), 32'h1);
            chk("all_id", 32'(out_id), 32'(k - 1));
         end
         adv();
      end
      @(negedge clock);
      chk("all_ack_end", 32'(result_ack), 32'h0);
      chk("all_id_last", 32'(out_id), 32'd3);
      chk("all_data_last", out_data, res_of(3));
      adv();
      @(negedge clock);
      chk("all_empty", 32'(out_valid), 32'h0);
      adv();

      for (int v = 0; v < 8; v++) begin
         BS_DONE = tbl[v].done;
         @(negedge clock);
         chk("tbl_ack", 32'(result_ack), 32'(tbl[v].ack));
         adv();
         BS_DONE = 4'b0000;
         @(negedge clock);
         chk("tbl_valid", 32'(out_valid), 32'(tbl[v].valid));
         chk("tbl_id", 32'(out_id), 32'(tbl[v].id));
         chk("tbl_data", out_data, tbl[v].data);
         chk("tbl_ack_once", 32'(result_ack), 32'h0);
         adv();
      end

      flush = 1'b1;
      @(negedge clock);
      adv();
      flush = 1'b0;

      // Fill to depth with out_ready low, then stall.
      out_ready = 1'b0;
      for (int k = 0; k < 8; k++) begin
         BS_DONE = 4'b1111;
         @(negedge clock);
         chk("fill_ack", 32'(result_ack), 32'(1) << ((1 + k) % 4));
         if (k == 0) chk("fill_rcnt0", 32'(result_count), 32'h0);
         adv();
      end
      for (int j = 1; j <= 3; j++) begin
         BS_DONE = 4'b1111;
         @(negedge clock);
         chk("stall_full", 32'(fifo_full), 32'h1);
         chk("stall_ack", 32'(result_ack), 32'h0);
         chk("stall_cnt", 32'(stall_count), STATS ? 32'(j - 1) : 32'h0);
         if (j == 1) chk("fill_rcnt", 32'(result_count), STATS ? 32'd8 : 32'h0);
         adv();
      end
      out_ready = 1'b1;
      BS_DONE   = 4'b1111;
      @(negedge clock);
      chk("pop_full_ack", 32'(result_ack), 32'b0010);
      chk("pop_full_id", 32'(out_id), 32'd1);
      chk("pop_full_data", out_data, res_of(1));
      chk("pop_stall_cnt", 32'(stall_count), STATS ? 32'd3 : 32'h0);
      adv();
      out_ready = 1'b0;
      BS_DONE   = 4'b0000;
      @(negedge clock);
      chk("still_full", 32'(fifo_full), 32'h1);
      chk("pop_rcnt", 32'(result_count), STATS ? 32'd9 : 32'h0);
      adv();
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clock);
         chk("drain_valid", 32'(out_valid), 32'h1);
         chk("drain_id", 32'(out_id), 32'((2 + k) % 4));
         adv();
      end
      @(negedge clock);
      chk("drain_empty", 32'(out_valid), 32'h0);
      adv();

      // Five entries, then flush with module 0 pending.
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         BS_DONE = 4'b1111;
         @(negedge clock);
         chk("five_ack", 32'(result_ack), 32'(1) << ((2 + k) % 4));
         adv();
      end
      flush   = 1'b1;
      BS_DONE = 4'b0001;
      @(negedge clock);
      chk("flush_ack", 32'(result_ack), 32'h0);
      chk("flush_valid", 32'(out_valid), 32'h0);
      adv();
      flush = 1'b0;
      @(negedge clock);
      chk("postflush_ack", 32'(result_ack), 32'b0001);
      chk("postflush_valid", 32'(out_valid), 32'h0);
      chk("postflush_full", 32'(fifo_full), 32'h0);
      chk("postflush_rcnt", 32'(result_count), 32'h0);
      adv();
      out_ready = 1'b1;
      @(negedge clock);
      chk("postflush_id", 32'(out_id), 32'd0);
      chk("postflush_data", out_data, res_of(0));
      chk("postflush_rcnt1", 32'(result_count), STATS ? 32'd1 : 32'h0);
      adv();

      // Reset mid-stream with modules 0 and 3 still holding BS_DONE.
      out_ready = 1'b0;
      BS_DONE   = 4'b1111;
      @(negedge clock);
      chk("mid_ack1", 32'(result_ack), 32'b0010);
      adv();
      @(negedge clock);
      chk("mid_ack2", 32'(result_ack), 32'b0100);
      adv();
      reset = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'h0);
      chk("mid_rst_data", out_data, 32'h0);
      chk("mid_rst_id", 32'(out_id), 32'h0);
      chk("mid_rst_full", 32'(fifo_full), 32'h0);
      chk("mid_rst_ack", 32'(result_ack), 32'h0);
      chk("mid_rst_rcnt", 32'(result_count), 32'h0);
      @(posedge clock);
      #1;
      reset     = 1'b1;
      out_ready = 1'b1;
      @(negedge clock);
      chk("rel_ack0", 32'(result_ack), 32'b0001);
      adv();
      @(negedge clock);
      chk("rel_ack3", 32'(result_ack), 32'b1000);
      chk("rel_id0", 32'(out_id), 32'd0);
      adv();
      @(negedge clock);
      chk("rel_ack_none", 32'(result_ack), 32'h0);
      chk("rel_id3", 32'(out_id), 32'd3);
      chk("rel_data3", out_data, res_of(3));
      adv();
      @(negedge clock);
      chk("rel_empty", 32'(out_valid), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
